// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the multicycle control unit and mult_div_unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (output start, op, a, b, input busy, done, hi, lo, div_zero);
  modport slave  (input start, op, a, b, output busy, done, hi, lo, div_zero);
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle Booth multiplier / restoring divider feeding HI/LO, fixed latency WIDTH+1.
// Division datapath is compiled only when MULT_DIV_UNIT_DIV_EN is defined.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  localparam int unsigned     PW      = 2 * WIDTH + 3;
  localparam int unsigned     CntW    = $clog2(WIDTH + 2);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             dz_q, dz_d;

  logic             accept, last;
  logic [WIDTH:0]   a_ext, b_ext, mcand_neg;
  logic [PW-1:0]    booth_sum, booth_next;

  assign accept    = bus.start && (state_q != StCalc);
  assign last      = (cnt_q == CntLast);
  // op[0]=0 selects signed: sign-extend, otherwise zero-extend to WIDTH+1
  assign a_ext     = {~bus.op[0] & bus.a[WIDTH-1], bus.a};
  assign b_ext     = {~bus.op[0] & bus.b[WIDTH-1], bus.b};
  assign mcand_neg = -mcand_q;

  always_comb begin
    case (prod_q[1:0])
      2'b01:   booth_sum = prod_q + {mcand_q, {(WIDTH + 2){1'b0}}};
      2'b10:   booth_sum = prod_q + {mcand_neg, {(WIDTH + 2){1'b0}}};
      default: booth_sum = prod_q;
    endcase
    booth_next = {booth_sum[PW-1], booth_sum[PW-1:1]};
  end

`ifdef MULT_DIV_UNIT_DIV_EN
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, dvnd_q, dvnd_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             div_signed;
  logic [WIDTH:0]   div_shift, div_diff;

  assign div_signed = ~bus.op[0];
  assign div_shift  = {rem_q, quo_q[WIDTH-1]};
  // MSB of the difference is the borrow: set means the trial subtract must be undone
  assign div_diff   = div_shift - {1'b0, dvsr_q};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    dvnd_d   = dvnd_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
`endif
    unique case (state_q)
      StIdle, StDone: state_d = accept ? StCalc : StIdle;
      StCalc: begin
        cnt_d  = cnt_q + CntW'(1);
        prod_d = booth_next;
`ifdef MULT_DIV_UNIT_DIV_EN
        if (!last) begin
          if (!div_diff[WIDTH]) begin
            rem_d = div_diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = div_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end
        if (last) begin
          state_d = StDone;
          if (!is_div_q) begin
            hi_d = booth_next[2*WIDTH:WIDTH+1];
            lo_d = booth_next[WIDTH:1];
          end else if (dvsr_q == '0) begin
            dz_d = 1'b1;
            hi_d = dvnd_q;
            lo_d = '1;
          end else begin
            hi_d = rneg_q ? -rem_q : rem_q;
            lo_d = qneg_q ? -quo_q : quo_q;
          end
        end
`else
        if (is_div_q) begin
          state_d = StDone;
        end else if (last) begin
          state_d = StDone;
          hi_d    = booth_next[2*WIDTH:WIDTH+1];
          lo_d    = booth_next[WIDTH:1];
        end
`endif
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      cnt_d    = '0;
      is_div_d = bus.op[1];
      prod_d   = {{(WIDTH + 1){1'b0}}, b_ext, 1'b0};
      mcand_d  = a_ext;
`ifdef MULT_DIV_UNIT_DIV_EN
      rem_d    = '0;
      quo_d    = (div_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      dvsr_d   = (div_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      dvnd_d   = bus.a;
      qneg_d   = div_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      rneg_d   = div_signed && bus.a[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      dvnd_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
`ifdef MULT_DIV_UNIT_DIV_EN
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      dvnd_q   <= dvnd_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
`endif
    end
  end

  assign bus.busy     = (state_q == StCalc);
  assign bus.done     = (state_q == StDone);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + random bench for mult_div_unit using a scoreboard of expected HI/LO results.
module tb_mult_div_unit;
  localparam int unsigned W = 32;
`ifdef MULT_DIV_UNIT_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif
  localparam logic [W-1:0] Min = {1'b1, {(W - 1){1'b0}}};

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int unsigned  lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the accept edge E0.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic signed [2*W-1:0] ps;
    logic [2*W-1:0] pu;
    e.dz  = 1'b0;
    e.lat = W + 1;
    e.hi  = '0;
    e.lo  = '0;
    case (o)
      2'b00: begin
        ps = $signed(x) * $signed(y);
        {e.hi, e.lo} = ps;
      end
      2'b01: begin
        pu = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        {e.hi, e.lo} = pu;
      end
      default: begin
        if (!DivEn) begin
          e.hi  = m_hi;
          e.lo  = m_lo;
          e.lat = 1;
        end else if (y == '0) begin
          e.lo = '1;
          e.hi = x;
          e.dz = 1'b1;
        end else if (o == 2'b11) begin
          e.lo = x / y;
          e.hi = x % y;
        end else if (x == Min && y == '1) begin
          e.lo = Min;
          e.hi = '0;
        end else begin
          e.lo = $signed(x) / $signed(y);
          e.hi = $signed(x) % $signed(y);
        end
      end
    endcase
    m_hi = e.hi;
    m_lo = e.lo;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~x;
    bus.b     = ~y;
  endtask

  // n counts negedges since E0; done must appear at n == latency.
  task automatic wait_done(input string tag, input int start_n);
    int n = start_n;
    int busy_bad = 0;
    exp_t e;
    while (bus.done !== 1'b1 && n < 200) begin
      if (bus.busy !== 1'b1) busy_bad++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy"}, 64'(busy_bad), 64'(0));
    chk({tag, "_done"}, 64'(bus.done), 64'(1));
    chk({tag, "_pending"}, 64'(sb.size()), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_lat"}, 64'(n), 64'(e.lat));
      chk({tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
      chk({tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
      chk({tag, "_dz"}, 64'(bus.div_zero), 64'(e.dz));
      chk({tag, "_busylow"}, 64'(bus.busy), 64'(0));
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) pulses++;
    end
    chk({tag, "_quiet"}, 64'(pulses), 64'(0));
  endtask

  initial begin
    logic [1:0] o;
    logic [W-1:0] x, y;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_dz", 64'(bus.div_zero), 64'(0));
    chk("rst_hi", 64'(bus.hi), 64'(0));
    chk("rst_lo", 64'(bus.lo), 64'(0));

    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg", 0);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 0);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mult_m1", 0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 0);
    issue(2'b10, Min, 32'hFFFF_FFFF);
    wait_done("div_ovf", 0);
    issue(2'b11, 32'h0000_1234, 32'd0);
    wait_done("divu_zero", 0);
    expect_quiet("after_dz", 3);

    // Operand changes and a second start while busy must be ignored.
    issue(2'b01, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd99;
    bus.b     = 32'd77;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("stable", 5);
    expect_quiet("stable", 40);

    // Back-to-back: second start in the done cycle.
    issue(2'b01, 32'd7, 32'd9);
    wait_done("b2b_first", 0);
    issue(2'b01, 32'd2, 32'd3);
    chk("b2b_busy", 64'(bus.busy), 64'(1));
    chk("b2b_nodone", 64'(bus.done), 64'(0));
    wait_done("b2b_second", 0);

    // Reset in the middle of a multiply.
    issue(2'b00, 32'd12345, 32'hFFFF_FFFE);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    chk("midrst_busy", 64'(bus.busy), 64'(0));
    chk("midrst_hi", 64'(bus.hi), 64'(0));
    chk("midrst_lo", 64'(bus.lo), 64'(0));
    expect_quiet("midrst", 40);
    issue(2'b00, 32'd100, 32'hFFFF_FFFB);
    wait_done("post_rst", 0);

    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if (o[1] && (i % 2 == 1)) y = 32'($urandom_range(1, 20));
      if (i == 5) y = '0;
      issue(o, x, y);
      wait_done("rand", 0);
    end

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
